fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer for the instruction cache. It owns the fetch PC and presents it to the icache. It accepts hit responses, advances the PC by 2 or 4 according to compression, and buffers fetched instructions in a small in-order queue toward decode. It also handles redirects, fetch enable/disable, queue back-pressure and miss/fetch statistics.

## Interface
- DEPTH, 4, instruction-queue entries; power of two, ≥2
- RESET_PC, 64'h0, fetch PC loaded on reset
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- fetch_en  in  1  level; 1 permits fetching
- pc  out  64  fetch address to icache (registered)
- fetch_req  out  1  PC is valid and a response will be accepted this cycle
- inst_valid  in  1  icache hit for current pc, same cycle
- inst_compressed  in  1  hit instruction is 16-bit
- inst  in  32  instruction bits (upper 16 don't-care when compressed)
- request  in  1  icache has a refill request outstanding (miss in progress)
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc
- redirect_pc  in  64  new fetch address; bit 0 forced to 0
- dec_valid  out  1  queue head valid
- dec_pc  out  64  head PC
- dec_inst  out  32  head instruction
- dec_compressed  out  1  head compression flag
- dec_ready  in  1  decode consumes head when dec_valid && dec_ready
- miss_cycles  out  32  saturating count of cycles spent in MISS
- inst_count  out  32  wrapping count of instructions pushed

## Operation
- States: IDLE, RUN, MISS.
- IDLE: fetch_req=0.
  - Goes to RUN on fetch_en=1.
- RUN: fetch_req = (count < DEPTH).
  - Goes to IDLE on fetch_en=0.
  - Goes to MISS when fetch_req && !inst_valid && request.
- MISS: fetch_req as in RUN.
  - Goes to RUN on inst_valid, or when request=0.
  - Goes to IDLE on fetch_en=0.
  - Increments miss_cycles each cycle spent in MISS; saturates at 32'hFFFF_FFFF.
- Accept = fetch_req && inst_valid && state≠IDLE && !redirect_valid. On accept:
  - push {pc, inst, inst_compressed} at the tail;
  - pc <= pc + (inst_compressed ? 2 : 4), modulo 2^64;
  - inst_count += 1.
- inst_valid while fetch_req=0 (queue full or IDLE) is ignored; pc holds and the same address is refetched later.
- Full check uses the count registered at cycle start. A pop in the same cycle does not free a slot until the next cycle (no pass-through).
- Pop = dec_valid && dec_ready.
  - Head advances; count -= 1.
  - Push and pop in the same cycle leave count unchanged.
- Redirect has highest priority:
  - pc <= {redirect_pc[63:1], 1'b0};
  - head, tail and count cleared;
  - any same-cycle accept is discarded;
  - a same-cycle pop is considered taken;
  - counters unaffected;
  - state: RUN/MISS → RUN, IDLE stays IDLE.
- Queue pointers are clog2(DEPTH) bits and wrap naturally; count is clog2(DEPTH)+1 bits.
- dec_* outputs come directly from queue storage at head. They are don't-care when dec_valid=0.

## Timing
- Reset (async assert, sync-safe release) sets:
  - pc=RESET_PC, state=IDLE, fetch_req=0;
  - count/head/tail=0, dec_valid=0;
  - miss_cycles=0, inst_count=0.
- pc, state, queue and counters are registered.
- fetch_req is combinational from state and count.
- dec_valid = (count≠0) is registered-derived.
- Icache lookup is combinational on registered pc: a hit asserted in cycle N is accepted in cycle N; pc shows the next address in N+1.
- Push-to-dec_valid latency: 1 cycle (entry visible the cycle after accept).
- Redirect asserted in cycle N: new pc and empty queue in N+1; first accept possible in N+1.
- fetch_en deasserted in cycle N: the accept in N still completes; IDLE with fetch_req=0 from N+1. Queue keeps draining in IDLE.
- Reset mid-operation: all state cleared immediately; queued instructions are lost.
- Sustained throughput: one instruction per cycle when hits are continuous and decode is always ready.

## Test plan
- Reset, fetch_en=1, hits every cycle with alternating compressed: pc sequence 0,4,6,10,12; decode sees matching dec_pc in order; inst_count=5.
- dec_ready=0, continuous hits, DEPTH=4: four accepts, then fetch_req=0 and pc held at 16. Raise dec_ready: one pop per cycle; fetch resumes the cycle after the first pop.
- Redirect to 0x1003 while queue holds 3 entries and a hit is present: the next cycle has pc=0x1002, dec_valid=0, inst_count unchanged by the discarded hit.
- inst_valid=0 with request=1 for 7 cycles, then a hit: MISS entered, miss_cycles=7, pc advances on the hit.
- Drop fetch_en with 2 entries queued: IDLE next cycle, no further accepts despite inst_valid=1; both entries drain; pc frozen.
- Assert rst_n low mid-stream with queue full: outputs immediately return to reset values (pc=RESET_PC, dec_valid=0, counters 0).

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the fetch PC, accepts icache hits into an in-order decode queue, handles redirects.
// Rev 1.0
`default_nettype none

module fetch_ctrl #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [63:0] pc,
    output logic        fetch_req,
    input  logic        inst_valid,
    input  logic        inst_compressed,
    input  logic [31:0] inst,
    input  logic        request,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        dec_valid,
    output logic [63:0] dec_pc,
    output logic [31:0] dec_inst,
    output logic        dec_compressed,
    input  logic        dec_ready,
    output logic [31:0] miss_cycles,
    output logic [31:0] inst_count
);

    localparam int            PW      = $clog2(DEPTH);
    localparam int            CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        MISS = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    logic [63:0]     q_pc   [DEPTH];
    logic [31:0]     q_inst [DEPTH];
    logic            q_comp [DEPTH];
    logic            accept;
    logic            pop;
    logic            unused_redirect_lsb;

    assign unused_redirect_lsb = redirect_pc[0];

    // Full check uses the count at cycle start, so a same-cycle pop never frees a slot.
    assign fetch_req      = (state != IDLE) && (count < DEPTH_C);
    assign accept         = fetch_req && inst_valid && !redirect_valid;
    assign dec_valid      = (count != '0);
    assign pop            = dec_valid && dec_ready;
    assign dec_pc         = q_pc[head];
    assign dec_inst       = q_inst[head];
    assign dec_compressed = q_comp[head];

    always_ff @(posedge clk) begin
        if (accept) begin
            q_pc[tail]   <= pc;
            q_inst[tail] <= inst;
            q_comp[tail] <= inst_compressed;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            miss_cycles <= '0;
            inst_count  <= '0;
        end else begin
            if (state == MISS && miss_cycles != '1) begin
                miss_cycles <= miss_cycles + 32'd1;
            end
            if (accept) begin
                inst_count <= inst_count + 32'd1;
            end

            if (redirect_valid) begin
                // Flush wins over any same-cycle push or pop.
                pc    <= {redirect_pc[63:1], 1'b0};
                head  <= '0;
                tail  <= '0;
                count <= '0;
                if (state != IDLE) begin
                    state <= RUN;
                end
            end else begin
                if (accept) begin
                    pc   <= pc + (inst_compressed ? 64'd2 : 64'd4);
                    tail <= tail + PW'(1);
                end
                if (pop) begin
                    head <= head + PW'(1);
                end
                count <= count + CW'(accept) - CW'(pop);

                case (state)
                    IDLE: begin
                        if (fetch_en) state <= RUN;
                    end
                    RUN: begin
                        if (!fetch_en)
                            state <= IDLE;
                        else if (fetch_req && !inst_valid && request)
                            state <= MISS;
                    end
                    MISS: begin
                        if (!fetch_en)
                            state <= IDLE;
                        else if (inst_valid || !request)
                            state <= RUN;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed stimulus for fetch_ctrl, checked every cycle against a queue-based model.
// Rev 1.0
`default_nettype none

module tb_fetch_ctrl;

    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic [63:0] pc;
    logic        fetch_req;
    logic        inst_valid;
    logic        inst_compressed;
    logic [31:0] inst;
    logic        request;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        dec_valid;
    logic [63:0] dec_pc;
    logic [31:0] dec_inst;
    logic        dec_compressed;
    logic        dec_ready;
    logic [31:0] miss_cycles;
    logic [31:0] inst_count;

    int checks = 0;
    int errors = 0;

    fetch_ctrl #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetch_en        (fetch_en),
        .pc              (pc),
        .fetch_req       (fetch_req),
        .inst_valid      (inst_valid),
        .inst_compressed (inst_compressed),
        .inst            (inst),
        .request         (request),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .dec_valid       (dec_valid),
        .dec_pc          (dec_pc),
        .dec_inst        (dec_inst),
        .dec_compressed  (dec_compressed),
        .dec_ready       (dec_ready),
        .miss_cycles     (miss_cycles),
        .inst_count      (inst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: fetching permitted / waiting on a refill, plus a plain queue of fetched entries.
    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        comp;
    } ent_t;

    ent_t        mq [$];
    logic [63:0] m_pc          = RESET_PC;
    logic        m_active      = 1'b0;
    logic        m_miss        = 1'b0;
    logic [31:0] m_miss_cycles = '0;
    logic [31:0] m_inst_count  = '0;
    logic        m_req;
    logic        m_acc;
    logic        m_pop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_pc          = RESET_PC;
            m_active      = 1'b0;
            m_miss        = 1'b0;
            m_miss_cycles = '0;
            m_inst_count  = '0;
        end else begin
            m_req = m_active && (mq.size() < DEPTH);
            m_acc = m_req && inst_valid && !redirect_valid;
            m_pop = (mq.size() != 0) && dec_ready;
            if (m_miss && m_miss_cycles != 32'hFFFF_FFFF) m_miss_cycles = m_miss_cycles + 1;
            if (m_acc) m_inst_count = m_inst_count + 1;
            if (redirect_valid) begin
                mq.delete();
                m_pc   = {redirect_pc[63:1], 1'b0};
                m_miss = 1'b0;
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_acc) begin
                    mq.push_back('{pc: m_pc, inst: inst, comp: inst_compressed});
                    m_pc = m_pc + (inst_compressed ? 64'd2 : 64'd4);
                end
                if (!m_active)
                    m_active = fetch_en;
                else if (!fetch_en) begin
                    m_active = 1'b0;
                    m_miss   = 1'b0;
                end else if (!m_miss)
                    m_miss = m_req && !inst_valid && request;
                else if (inst_valid || !request)
                    m_miss = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("m_pc", pc, m_pc);
        chk("m_fetch_req", {63'd0, fetch_req}, {63'd0, m_active && (mq.size() < DEPTH)});
        chk("m_dec_valid", {63'd0, dec_valid}, {63'd0, mq.size() != 0});
        if (mq.size() != 0) begin
            chk("m_dec_pc", dec_pc, mq[0].pc);
            chk("m_dec_inst", {32'd0, dec_inst}, {32'd0, mq[0].inst});
            chk("m_dec_comp", {63'd0, dec_compressed}, {63'd0, mq[0].comp});
        end
        chk("m_miss_cycles", {32'd0, miss_cycles}, {32'd0, m_miss_cycles});
        chk("m_inst_count", {32'd0, inst_count}, {32'd0, m_inst_count});
    endtask

    // Compare at the falling edge, then return just after the next rising edge.
    task automatic cyc();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    logic [63:0] t1_pc  [5] = '{64'd4, 64'd6, 64'd10, 64'd12, 64'd16};
    logic [63:0] t1_dec [5] = '{64'd0, 64'd4, 64'd6, 64'd10, 64'd12};

    initial begin
        rst_n           = 1'b0;
        fetch_en        = 1'b0;
        inst_valid      = 1'b0;
        inst_compressed = 1'b0;
        inst            = '0;
        request         = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        dec_ready       = 1'b0;
        cyc();
        cyc();
        chk("rst_pc", pc, 64'd0);
        chk("rst_fetch_req", {63'd0, fetch_req}, 64'd0);
        chk("rst_dec_valid", {63'd0, dec_valid}, 64'd0);
        chk("rst_miss_cycles", {32'd0, miss_cycles}, 64'd0);
        chk("rst_inst_count", {32'd0, inst_count}, 64'd0);

        // Continuous hits, alternating 32/16-bit, decode always ready.
        rst_n     = 1'b1;
        fetch_en  = 1'b1;
        dec_ready = 1'b1;
        cyc();
        for (int i = 0; i < 5; i++) begin
            inst_valid      = 1'b1;
            inst_compressed = 1'(i % 2);
            inst            = 32'hA000_0000 + 32'(i);
            cyc();
            chk("t1_pc", pc, t1_pc[i]);
            chk("t1_dec_pc", dec_pc, t1_dec[i]);
        end
        inst_valid = 1'b0;
        cyc();
        chk("t1_inst_count", {32'd0, inst_count}, 64'd5);
        chk("t1_drained", {63'd0, dec_valid}, 64'd0);

        // Back-pressure: queue fills, fetch stalls, resumes one cycle after first pop.
        do_reset();
        cyc();
        dec_ready       = 1'b0;
        inst_valid      = 1'b1;
        inst_compressed = 1'b0;
        for (int i = 0; i < 4; i++) begin
            inst = 32'hB000_0000 + 32'(i);
            cyc();
            chk("t2_fill_pc", pc, 64'(4 * (i + 1)));
        end
        cyc();
        chk("t2_full_req", {63'd0, fetch_req}, 64'd0);
        chk("t2_full_pc", pc, 64'd16);
        dec_ready = 1'b1;
        cyc();
        chk("t2_pop_pc", pc, 64'd16);
        chk("t2_pop_req", {63'd0, fetch_req}, 64'd1);
        chk("t2_pop_head", dec_pc, 64'd4);
        cyc();
        chk("t2_resume_pc", pc, 64'd20);

        // Redirect with 3 entries queued and a hit present.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h1003;
        cyc();
        redirect_valid = 1'b0;
        inst_valid     = 1'b0;
        chk("t3_pc", pc, 64'h1002);
        chk("t3_dec_valid", {63'd0, dec_valid}, 64'd0);
        chk("t3_inst_count", {32'd0, inst_count}, 64'd5);

        // Miss: 7 cycles without hit while refill outstanding, then a hit.
        request = 1'b1;
        repeat (7) cyc();
        chk("t4_miss_pre", {32'd0, miss_cycles}, 64'd6);
        inst_valid      = 1'b1;
        inst_compressed = 1'b0;
        inst            = 32'hC000_0001;
        cyc();
        chk("t4_miss_cycles", {32'd0, miss_cycles}, 64'd7);
        chk("t4_pc", pc, 64'h1006);
        request = 1'b0;

        // Disable with 2 entries queued; queue drains in IDLE, pc frozen.
        dec_ready       = 1'b0;
        inst_compressed = 1'b1;
        inst            = 32'h0000_C002;
        cyc();
        chk("t5_pc", pc, 64'h1008);
        chk("t5_head", dec_pc, 64'h1002);
        fetch_en   = 1'b0;
        inst_valid = 1'b0;
        cyc();
        chk("t5_idle_req", {63'd0, fetch_req}, 64'd0);
        inst_valid = 1'b1;
        dec_ready  = 1'b1;
        cyc();
        chk("t5_drain_pc", pc, 64'h1008);
        chk("t5_drain_head", dec_pc, 64'h1006);
        cyc();
        chk("t5_empty", {63'd0, dec_valid}, 64'd0);
        chk("t5_frozen_pc", pc, 64'h1008);
        chk("t5_inst_count", {32'd0, inst_count}, 64'd7);

        // Asynchronous reset with the queue full.
        fetch_en        = 1'b1;
        dec_ready       = 1'b0;
        inst_compressed = 1'b0;
        repeat (6) cyc();
        chk("t6_full_req", {63'd0, fetch_req}, 64'd0);
        chk("t6_full_valid", {63'd0, dec_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_pc", pc, RESET_PC);
        chk("t6_async_dec_valid", {63'd0, dec_valid}, 64'd0);
        chk("t6_async_req", {63'd0, fetch_req}, 64'd0);
        chk("t6_async_miss", {32'd0, miss_cycles}, 64'd0);
        chk("t6_async_icnt", {32'd0, inst_count}, 64'd0);
        fetch_en   = 1'b0;
        inst_valid = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;

        // Redirect in IDLE stays IDLE; pc wraps modulo 2^64.
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
        cyc();
        redirect_valid = 1'b0;
        chk("t7_pc_align", pc, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("t7_idle_req", {63'd0, fetch_req}, 64'd0);
        fetch_en = 1'b1;
        cyc();
        chk("t7_run_req", {63'd0, fetch_req}, 64'd1);
        inst_valid      = 1'b1;
        inst_compressed = 1'b1;
        dec_ready       = 1'b1;
        inst            = 32'h0000_D003;
        cyc();
        inst_valid = 1'b0;
        chk("t7_pc_wrap", pc, 64'd0);
        chk("t7_head", dec_pc, 64'hFFFF_FFFF_FFFF_FFFE);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
